udp_hdr_insert: RTL
===================

# udp_hdr_insert

Downstream neighbour of the UDP length/checksum stage: consumes the payload stream with its per-packet IP/port header, payload byte length and 16-bit one's-complement payload sum, and emits a complete UDP datagram (8-byte UDP header prepended, checksum including the IPv4 pseudo-header) toward the IPv4 framing stage. Payload is never buffered; upstream is stalled while the header is built.

## Interface
- Parameters: none.
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `hdr_ip_dest_i`, `hdr_ip_src_i` in 32 each: IPv4 addresses; stable while `user_tvld_i` is high.
- `hdr_port_dest_i`, `hdr_port_src_i` in 16 each: UDP ports.
- `user_data_len_i` in 16: payload bytes.
- `user_data_csum_i` in 16: folded one's-complement sum of payload; invalid bytes are zero.
- `user_tdata_i` in 32, `user_tkeep_i` in 4, `user_tlast_i` in 1, `user_tvld_i` in 1, `user_trdy_o` out 1: payload AXI-S; byte [31:24] is first on wire.
- `ip_dest_o`, `ip_src_o` out 32 each: addresses for the IP stage.
- `udp_len_o` out 16: `user_data_len_i + 8`.
- `err_len_o` out 1: sticky; set when `user_data_len_i > 65527`.
- `user_tdata_o` out 32, `user_tkeep_o` out 4, `user_tlast_o` out 1, `user_tvld_o` out 1, `user_trdy_i` in 1: datagram AXI-S.

## Operation
- FSM: IDLE -> CALC -> FOLD -> HDR0 -> HDR1 -> PAYLOAD -> IDLE.
- IDLE: `user_trdy_o`=0. When `user_tvld_i`=1, latch all header inputs, length, and csum; go to CALC. No beat is consumed.
- `udp_len` = `user_data_len_i + 8`, modulo 2^16. On overflow, `err_len_o` is set and the packet is still sent.
- CALC: 5 cycles. Each cycle adds two 16-bit terms into a 20-bit accumulator. Terms: ip_src hi/lo, ip_dst hi/lo, 0x0011, udp_len (pseudo-header), port_src, port_dest, udp_len, data_csum.
- FOLD: `s = acc[15:0] + acc[19:16]`, then `s = s[15:0] + s[16]`, then `csum = ~s`. A result of 0x0000 is transmitted as 0xFFFF.
- HDR0: output `{port_src, port_dest}`, tkeep=0xF, tlast=0.
- HDR1: output `{udp_len, csum}`, tkeep=0xF, tlast=0.
- Each HDR state advances when the output register loads (`!user_tvld_o | user_trdy_i`).
- PAYLOAD: pass-through via the output register.
  - `user_trdy_o = !user_tvld_o | user_trdy_i`.
  - tdata, tkeep, and tlast are copied unchanged.
  - On the accepted input beat with `user_tlast_i`=1, return to IDLE.
- `ip_dest_o`, `ip_src_o`, `udp_len_o` update at HDR0 entry and hold until the next HDR0.

## Timing
- Reset values:
  - state IDLE.
  - `user_tvld_o`, `user_tlast_o`, `err_len_o` = 0.
  - `user_tdata_o`, `user_tkeep_o`, `ip_*_o`, `udp_len_o` = 0.
  - `user_trdy_o` = 0.
- Header latch in IDLE at cycle T:
  - CALC occupies T+1..T+5, FOLD T+6, HDR0 T+7.
  - Word0 is valid at T+8 and word1 at T+9 with `user_trdy_i`=1.
  - The first payload beat is accepted at T+9, so payload appears from T+10.
- Output handshake: while `user_tvld_o & !user_trdy_i`, all outputs hold and nothing advances.
- After the tlast beat is accepted, the FSM is IDLE next cycle. A new packet's header can latch in that cycle, giving a 1-cycle minimum bubble at the input.
- Reset mid-packet: the FSM returns to IDLE and `user_tvld_o` drops the next cycle. The partial datagram is abandoned; there is no tlast recovery.
- Single-beat payload: tlast on the first PAYLOAD beat returns to IDLE directly.

## Configuration
- `UDP_HDR_CSUM_EN` defined:
  - Checksum is computed as above.
- `UDP_HDR_CSUM_EN` undefined:
  - CALC and FOLD are absent; IDLE goes directly to HDR0, and the checksum field is 0x0000.
  - Word0 is valid at T+2.
  - The accumulator is not synthesized.

## Test plan
- Basic checksum:
  - Stimulus: ip_src=0xC0A80001, ip_dst=0xC0A80002, ports 0x1234/0x5678, len=4, csum=0x0000, one beat 0x00000000 with tkeep=0xF and tlast.
  - Response: words 0x12345678, 0x000C15D6, then 0x00000000 with tlast; `udp_len_o`=0x000C.
- Zero-checksum substitution:
  - Stimulus: addresses=0, ports=0, len=4, csum=0xFFD6.
  - Response: word1 = 0x000CFFFF.
- Backpressure:
  - Stimulus: 3-beat payload with `user_trdy_i` toggling 1/0 every cycle.
  - Response: 5 output words in order with no duplicates and no loss; tkeep=0x3 on the last beat is preserved.
- Back-to-back packets:
  - Stimulus: two packets with different ports.
  - Response: the second header latches the cycle after the first tlast is accepted; outputs do not interleave.
- Length overflow:
  - Stimulus: len=65530.
  - Response: `udp_len_o`=0x0002 and `err_len_o` is set and stays 1 until reset.
- Reset mid-CALC and mid-PAYLOAD:
  - Response: `user_tvld_o`=0 the cycle after reset and the FSM is in IDLE.
  - With `UDP_HDR_CSUM_EN` undefined, rerun the basic checksum case: word1 = 0x000C0000, and word0 appears at T+2.

Source files
------------

// File: rtl/udp_hdr_insert.sv
// udp_hdr_insert
// Prepends the 8-byte UDP header to a payload stream that arrives with its
// per-packet addresses, ports, payload length and payload one's-complement sum.
// The payload is never buffered: upstream is stalled (user_trdy_o = 0) while
// the header words are produced, then beats pass through one output register.
//
// Build option: define UDP_HDR_CSUM_EN to compute the UDP checksum including
// the IPv4 pseudo-header (CALC/FOLD states and the accumulator). Without it the
// FSM goes IDLE -> HDR0 directly and the checksum field is 0x0000.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   hdr_ip_dest_i/hdr_ip_src_i       IPv4 addresses (stable while user_tvld_i)
//   hdr_port_dest_i/hdr_port_src_i   UDP ports
//   user_data_len_i, user_data_csum_i payload length and folded payload sum
//   user_t*_i / user_trdy_o          payload AXI-S input (byte [31:24] first)
//   ip_dest_o, ip_src_o, udp_len_o   header info for the IP stage
//   err_len_o                        sticky length-overflow flag
//   user_t*_o / user_trdy_i          datagram AXI-S output
module udp_hdr_insert (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hdr_ip_dest_i,
    input  logic [31:0] hdr_ip_src_i,
    input  logic [15:0] hdr_port_dest_i,
    input  logic [15:0] hdr_port_src_i,
    input  logic [15:0] user_data_len_i,
    input  logic [15:0] user_data_csum_i,
    input  logic [31:0] user_tdata_i,
    input  logic [3:0]  user_tkeep_i,
    input  logic        user_tlast_i,
    input  logic        user_tvld_i,
    output logic        user_trdy_o,
    output logic [31:0] ip_dest_o,
    output logic [31:0] ip_src_o,
    output logic [15:0] udp_len_o,
    output logic        err_len_o,
    output logic [31:0] user_tdata_o,
    output logic [3:0]  user_tkeep_o,
    output logic        user_tlast_o,
    output logic        user_tvld_o,
    input  logic        user_trdy_i
);

`ifdef UDP_HDR_CSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_CALC = 3'd1, ST_FOLD = 3'd2,
        ST_HDR0 = 3'd3, ST_HDR1 = 3'd4, ST_PAYLOAD = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_HDR0 = 3'd3, ST_HDR1 = 3'd4, ST_PAYLOAD = 3'd5
    } state_t;
`endif

    state_t      state_r, state_s;
    logic [31:0] ip_src_r, ip_dst_r;
    logic [15:0] port_src_r, port_dst_r, udp_len_r;
    logic [15:0] csum_s, udp_len_nx_s;
    logic        load_s, latch_s, ovf_s, hdr0_entry_s;
    logic [31:0] hdr_ip_src_s, hdr_ip_dst_s;
    logic [15:0] hdr_udp_len_s;

    // Output register may load when it is empty or being drained this cycle.
    assign load_s        = !user_tvld_o || user_trdy_i;
    assign latch_s       = (state_r == ST_IDLE) && user_tvld_i;
    assign udp_len_nx_s  = user_data_len_i + 16'd8;
    assign ovf_s         = (user_data_len_i > 16'd65527);
    assign hdr0_entry_s  = (state_s == ST_HDR0) && (state_r != ST_HDR0);
    // Without the checksum path HDR0 is entered on the latch edge itself, so
    // the IP-stage outputs must take the live inputs in that case.
    assign hdr_ip_src_s  = latch_s ? hdr_ip_src_i  : ip_src_r;
    assign hdr_ip_dst_s  = latch_s ? hdr_ip_dest_i : ip_dst_r;
    assign hdr_udp_len_s = latch_s ? udp_len_nx_s  : udp_len_r;

`ifdef UDP_HDR_CSUM_EN
    logic [15:0] data_csum_r, csum_r, term_a_s, term_b_s;
    logic [19:0] acc_r;
    logic [2:0]  calc_cnt_r;

    // Fold the 20-bit accumulator to 16 bits and complement; 0 is sent as 0xFFFF.
    function automatic logic [15:0] csum_fold(input logic [19:0] acc);
        logic [16:0] s;
        logic [15:0] c;
        s = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
        s = {1'b0, s[15:0]} + {16'd0, s[16]};
        c = ~s[15:0];
        csum_fold = (c == 16'h0000) ? 16'hFFFF : c;
    endfunction

    // Select the two checksum terms added on each CALC cycle.
    always_comb begin
        term_a_s = 16'h0000;
        term_b_s = 16'h0000;
        case (calc_cnt_r)
            3'd0: begin term_a_s = ip_src_r[31:16]; term_b_s = ip_src_r[15:0]; end
            3'd1: begin term_a_s = ip_dst_r[31:16]; term_b_s = ip_dst_r[15:0]; end
            3'd2: begin term_a_s = 16'h0011;        term_b_s = udp_len_r;      end
            3'd3: begin term_a_s = port_src_r;      term_b_s = port_dst_r;     end
            3'd4: begin term_a_s = udp_len_r;       term_b_s = data_csum_r;    end
            default: begin term_a_s = 16'h0000;     term_b_s = 16'h0000;       end
        endcase
    end

    // Checksum accumulator, CALC cycle counter and folded result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r       <= 20'd0;
            calc_cnt_r  <= 3'd0;
            csum_r      <= 16'h0000;
            data_csum_r <= 16'h0000;
        end else if (latch_s) begin
            acc_r       <= 20'd0;
            calc_cnt_r  <= 3'd0;
            data_csum_r <= user_data_csum_i;
        end else if (state_r == ST_CALC) begin
            acc_r      <= acc_r + {4'd0, term_a_s} + {4'd0, term_b_s};
            calc_cnt_r <= calc_cnt_r + 3'd1;
        end else if (state_r == ST_FOLD) begin
            csum_r <= csum_fold(acc_r);
        end
    end

    assign csum_s = csum_r;
`else
    logic unused_csum_s;
    assign unused_csum_s = ^user_data_csum_i;
    assign csum_s        = 16'h0000;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and input-side ready.
    always_comb begin
        state_s     = state_r;
        user_trdy_o = 1'b0;
        case (state_r)
            ST_IDLE: begin
`ifdef UDP_HDR_CSUM_EN
                if (user_tvld_i) state_s = ST_CALC; else state_s = ST_IDLE;
`else
                if (user_tvld_i) state_s = ST_HDR0; else state_s = ST_IDLE;
`endif
            end
`ifdef UDP_HDR_CSUM_EN
            ST_CALC: begin
                if (calc_cnt_r == 3'd4) state_s = ST_FOLD; else state_s = ST_CALC;
            end
            ST_FOLD: state_s = ST_HDR0;
`endif
            ST_HDR0: begin
                if (load_s) state_s = ST_HDR1; else state_s = ST_HDR0;
            end
            ST_HDR1: begin
                if (load_s) state_s = ST_PAYLOAD; else state_s = ST_HDR1;
            end
            ST_PAYLOAD: begin
                user_trdy_o = load_s;
                if (load_s && user_tvld_i && user_tlast_i) state_s = ST_IDLE;
                else state_s = ST_PAYLOAD;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Per-packet header latch and sticky length error.
    always_ff @(posedge clk) begin
        if (reset) begin
            ip_src_r   <= 32'd0;
            ip_dst_r   <= 32'd0;
            port_src_r <= 16'd0;
            port_dst_r <= 16'd0;
            udp_len_r  <= 16'd0;
            err_len_o  <= 1'b0;
        end else if (latch_s) begin
            ip_src_r   <= hdr_ip_src_i;
            ip_dst_r   <= hdr_ip_dest_i;
            port_src_r <= hdr_port_src_i;
            port_dst_r <= hdr_port_dest_i;
            udp_len_r  <= udp_len_nx_s;
            err_len_o  <= err_len_o | ovf_s;
        end
    end

    // IP-stage outputs, refreshed on entry to HDR0 and held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            ip_src_o  <= 32'd0;
            ip_dest_o <= 32'd0;
            udp_len_o <= 16'd0;
        end else if (hdr0_entry_s) begin
            ip_src_o  <= hdr_ip_src_s;
            ip_dest_o <= hdr_ip_dst_s;
            udp_len_o <= hdr_udp_len_s;
        end
    end

    // Output register: header words, then payload pass-through.
    always_ff @(posedge clk) begin
        if (reset) begin
            user_tdata_o <= 32'd0;
            user_tkeep_o <= 4'd0;
            user_tlast_o <= 1'b0;
            user_tvld_o  <= 1'b0;
        end else if (load_s) begin
            case (state_r)
                ST_HDR0: begin
                    user_tdata_o <= {port_src_r, port_dst_r};
                    user_tkeep_o <= 4'hF;
                    user_tlast_o <= 1'b0;
                    user_tvld_o  <= 1'b1;
                end
                ST_HDR1: begin
                    user_tdata_o <= {udp_len_r, csum_s};
                    user_tkeep_o <= 4'hF;
                    user_tlast_o <= 1'b0;
                    user_tvld_o  <= 1'b1;
                end
                ST_PAYLOAD: begin
                    user_tdata_o <= user_tdata_i;
                    user_tkeep_o <= user_tkeep_i;
                    user_tlast_o <= user_tlast_i;
                    user_tvld_o  <= user_tvld_i;
                end
                default: begin
                    user_tvld_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
